// File: rtl/main_memory_responder.sv
// Word-addressed memory model answering cache-controller requests after a fixed wait.
// Define MEM_BUSY_ERR_EN to flag strobes that arrive while an access is in flight.
module main_memory_responder #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MReady,
  output logic              MBusy,
  output logic              MErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_DONE
  } state_t;

  localparam logic [7:0] WC = 8'(WAIT_CYCLES);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately outside the reset domain; an aborted access never reaches XFER.
  always_ff @(posedge clk) begin
    if (state_q == S_XFER && rw_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    unique case (state_q)
      S_IDLE: begin
        if (MStrobe) begin
          rw_d    = MRW;
          addr_d  = MAddr;
          wdata_d = MDataIn;
          cnt_d   = WC;
          state_d = (WC == 8'd0) ? S_XFER : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end
        if (cnt_q <= 8'd1) begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (!rw_q) begin
          dout_d = mem[addr_q];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
`ifdef MEM_BUSY_ERR_EN
    err_d = err_q | (MStrobe & (state_q != S_IDLE));
`else
    err_d = 1'b0;
`endif
  end

  always_comb begin
    MReady   = (state_q == S_DONE);
    MBusy    = (state_q != S_IDLE);
    MDataOut = dout_q;
    MErr     = err_q;
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench: expected completions queued at request time, popped on MReady.
// A second instance with zero wait states covers the minimum-latency path.
module tb_main_memory_responder;

  localparam int W = 4;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MStrobe = 1'b0;
  logic        MRW = 1'b0;
  logic [9:0]  MAddr = '0;
  logic [31:0] MDataIn = '0;
  logic [31:0] MDataOut;
  logic        MReady, MBusy, MErr;

  logic        z_strobe = 1'b0;
  logic        z_rw = 1'b0;
  logic [9:0]  z_addr = '0;
  logic [31:0] z_din = '0;
  logic [31:0] z_dout;
  logic        z_ready, z_busy, z_err;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] model [8];
  bit   err_exp;

  main_memory_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW),
    .MAddr(MAddr), .MDataIn(MDataIn), .MDataOut(MDataOut),
    .MReady(MReady), .MBusy(MBusy), .MErr(MErr)
  );

  main_memory_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .MStrobe(z_strobe), .MRW(z_rw),
    .MAddr(z_addr), .MDataIn(z_din), .MDataOut(z_dout),
    .MReady(z_ready), .MBusy(z_busy), .MErr(z_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && MReady) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("ready_cyc", 64'(cyc), 64'(e.cyc));
        if (e.rd) chk("rdata", MDataOut, e.data);
      end
    end
  end

  task automatic wait_idle(input string tag, input int exp_cyc);
    for (int i = 0; i < 300 && MBusy; i++) @(negedge clk);
    chk({tag, "_idle"}, MBusy, 0);
    chk({tag, "_idle_cyc"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_sb_drain"}, 64'(sb.size()), 0);
  endtask

  task automatic req(input string tag, input bit wr, input logic [9:0] a,
                     input logic [31:0] d, input logic [31:0] rexp,
                     input int poke);
    int t0;
    @(negedge clk);
    MStrobe = 1'b1;
    MRW     = wr;
    MAddr   = a;
    MDataIn = d;
    @(posedge clk);
    #1;
    t0 = cyc;
    sb.push_back('{rd: !wr, data: rexp, cyc: t0 + W + 1});
    chk({tag, "_busy_t0"}, MBusy, 1);
    @(negedge clk);
    MStrobe = 1'b0;
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      MStrobe = 1'b1;
      MRW     = 1'b1;
      MAddr   = 10'h3AA;
      MDataIn = 32'hBAD0BAD0;
      @(negedge clk);
      MStrobe = 1'b0;
    end
    wait_idle(tag, t0 + W + 2);
  endtask

  initial begin
    int t0;
`ifdef MEM_BUSY_ERR_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    #3 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", MBusy, 0);
    chk("rst_ready", MReady, 0);
    chk("rst_dout", MDataOut, 0);
    chk("rst_err", MErr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    req("wr5", 1'b1, 10'h005, 32'hDEADBEEF, 32'h0, 0);
    req("rd5", 1'b0, 10'h005, 32'h0, 32'hDEADBEEF, 0);
    req("wr6", 1'b1, 10'h006, 32'h01234567, 32'h0, 0);
    chk("dout_hold", MDataOut, 32'hDEADBEEF);

    @(negedge clk);
    z_strobe = 1'b1;
    z_rw     = 1'b0;
    z_addr   = 10'h3FF;
    @(posedge clk);
    #1;
    t0 = cyc;
    @(negedge clk);
    z_strobe = 1'b0;
    chk("w0_ready_early", z_ready, 0);
    @(negedge clk);
    chk("w0_ready_cyc", 64'(cyc - t0), 1);
    chk("w0_ready", z_ready, 1);
    @(negedge clk);
    chk("w0_idle", z_busy, 0);

    req("wr10", 1'b1, 10'h010, 32'hA5A5A5A5, 32'h0, 0);
    @(negedge clk);
    MStrobe = 1'b1;
    MRW     = 1'b1;
    MAddr   = 10'h010;
    MDataIn = 32'h12345678;
    @(negedge clk);
    MStrobe = 1'b0;
    @(negedge clk);
    chk("abort_busy_pre", MBusy, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", MBusy, 0);
    chk("abort_ready", MReady, 0);
    chk("abort_dout", MDataOut, 0);
    chk("abort_err", MErr, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    req("rd10", 1'b0, 10'h010, 32'h0, 32'hA5A5A5A5, 0);

    for (int i = 0; i < 4; i++) begin
      model[i] = $urandom;
      req("wr_loop", 1'b1, 10'h030 + 10'(i), model[i], 32'h0, 0);
    end
    for (int i = 3; i >= 0; i--) begin
      req("rd_loop", 1'b0, 10'h030 + 10'(i), 32'h0, model[i], 0);
    end

    req("wr_poke", 1'b1, 10'h020, 32'hCAFEF00D, 32'h0, 1);
    chk("err_set", MErr, 64'(err_exp));
    req("rd_poke", 1'b0, 10'h020, 32'h0, 32'hCAFEF00D, 0);
    chk("err_sticky", MErr, 64'(err_exp));
    req("rd_3aa", 1'b0, 10'h3AA, 32'h0, 32'h0, 0);

    @(negedge clk);
    MStrobe = 1'b1;
    MRW     = 1'b0;
    MAddr   = 10'h005;
    @(posedge clk);
    #1;
    t0 = cyc;
    sb.push_back('{rd: 1'b1, data: 32'hDEADBEEF, cyc: t0 + W + 1});
    sb.push_back('{rd: 1'b1, data: 32'hDEADBEEF, cyc: t0 + 2 * W + 4});
    for (int i = 0; i < 50 && cyc < t0 + W + 3; i++) @(negedge clk);
    MStrobe = 1'b0;
    chk("b2b_busy", MBusy, 1);
    wait_idle("b2b", t0 + 2 * W + 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width; memory holds 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 4, wait-state count, legal range 0..255.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port MStrobe  input  1  access request from the cache controller, sampled only in IDLE.
REQ-007 SHALL have port MRW  input  1  access direction: 1 = write, 0 = read; sampled with MStrobe.
REQ-008 SHALL have port MAddr  input  ADDR_W  word address; sampled with MStrobe.
REQ-009 SHALL have port MDataIn  input  DATA_W  write data; sampled with MStrobe.
REQ-010 SHALL have port MDataOut  output  DATA_W  registered read data.
REQ-011 SHALL have port MReady  output  1  one-cycle completion pulse.
REQ-012 SHALL have port MBusy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port MErr  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-014 SHALL implement a 4-state FSM: IDLE, WAIT, XFER, DONE.
REQ-015 IDLE with MStrobe=1 at edge T0: SHALL latch MRW, MAddr, MDataIn and load the 8-bit counter with WAIT_CYCLES; next state is WAIT, or XFER when WAIT_CYCLES=0.
REQ-016 IDLE with MStrobe=0: SHALL stay in IDLE with no latch and no array access.
REQ-017 WAIT: SHALL decrement the counter each edge; when the counter equals 1, next state is XFER. The counter SHALL never wrap below 0.
REQ-018 XFER, write: SHALL write the latched data to array[latched addr] at the XFER-exit edge.
REQ-019 XFER, read: SHALL load MDataOut from array[latched addr] at the same edge; MDataOut SHALL be unchanged by writes.
REQ-020 XFER: SHALL always go to DONE.
REQ-021 DONE: MReady=1 for exactly one cycle; SHALL always return to IDLE; MStrobe in DONE SHALL be ignored.
REQ-022 Latency: MReady SHALL be high in the cycle following edge T0+WAIT_CYCLES+1, and a new request SHALL be accepted no earlier than edge T0+WAIT_CYCLES+3.
REQ-023 MDataOut SHALL hold its value until the next read completes.
REQ-024 MStrobe held high continuously SHALL start back-to-back accesses, each one sampled on the first IDLE edge.

Reset
REQ-025 Reset asserted SHALL immediately force state=IDLE, counter=0, MReady=0, MBusy=0, MDataOut=0, MErr=0, and clear the latched request registers.
REQ-026 Reset mid-access SHALL abort the access; no array write SHALL occur, and no MReady SHALL follow deassertion.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro MEM_BUSY_ERR_EN: when defined, MStrobe=1 sampled in WAIT, XFER or DONE SHALL set MErr at that edge; MErr stays set until reset.
REQ-029 MEM_BUSY_ERR_EN undefined: MErr SHALL be tied to 0 and strobes while busy are silently ignored; all other behaviour is identical.

Verification
REQ-030 Reset, then pulse MStrobe=1, MRW=1, MAddr=0x005, MDataIn=0xDEADBEEF at edge T0 (WAIT_CYCLES=4) -> MBusy high from T0; MReady high only in the cycle after edge T0+5; MBusy low after T0+6.
REQ-031 Read MAddr=0x005 after REQ-030 -> MDataOut=0xDEADBEEF together with MReady; MDataOut still 0xDEADBEEF after a later write to 0x006.
REQ-032 WAIT_CYCLES=0, read of an unwritten reset-time address -> MReady in the cycle after edge T0+1.
REQ-033 Reset asserted during WAIT of a write of 0x12345678 to 0x010 -> outputs 0 at once; no MReady; a subsequent read of 0x010 does not return 0x12345678.
REQ-034 MEM_BUSY_ERR_EN defined, MStrobe pulsed during WAIT -> MErr=1 and sticky, current access completes normally; undefined -> MErr=0 and the extra strobe is ignored.
